// File: rtl/display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | display_pkg                                                                |
// | Shared raster-timing defaults, derived total functions and the per-pixel   |
// | control word carried down the scanout pipeline.                            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package display_pkg;

  localparam int unsigned c_h_active_def = 640;
  localparam int unsigned c_h_fp_def     = 16;
  localparam int unsigned c_h_sync_def   = 96;
  localparam int unsigned c_h_bp_def     = 48;
  localparam int unsigned c_v_active_def = 480;
  localparam int unsigned c_v_fp_def     = 10;
  localparam int unsigned c_v_sync_def   = 2;
  localparam int unsigned c_v_bp_def     = 33;
  localparam int unsigned c_fb_addr_w_def = 16;

  // Control word that travels alongside each pixel from counter stage to output.
  typedef struct packed {
    logic       active;  // inside the visible raster
    logic       show;    // visible and scanout enabled for this frame
    logic [1:0] k;       // byte lane of the pixel within its fetched word
    logic       hs;      // hsync asserted (logical, before polarity)
    logic       vs;      // vsync asserted (logical, before polarity)
    logic       fs;      // raster pixel (0,0)
    logic       vact;    // line is one of the visible lines
  } pix_ctl_t;

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  // Four pixels are packed per word, so a line must hold whole words.
  function automatic bit h_active_ok(input int unsigned act);
    return (act % 4) == 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_timing                                                               |
// | Horizontal/vertical raster counters and the stage-0 flags derived from     |
// | them.                                                                      |
// | Ports: clk, reset (async, active-low); active, vactive, hsync_on,          |
// |        vsync_on, frame_boundary, frame_first, lane[1:0] (all combinational |
// |        from the counter registers).                                        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module video_timing
  import display_pkg::*;
#(
  parameter int unsigned H_ACTIVE = c_h_active_def,
  parameter int unsigned H_FP     = c_h_fp_def,
  parameter int unsigned H_SYNC   = c_h_sync_def,
  parameter int unsigned H_BP     = c_h_bp_def,
  parameter int unsigned V_ACTIVE = c_v_active_def,
  parameter int unsigned V_FP     = c_v_fp_def,
  parameter int unsigned V_SYNC   = c_v_sync_def,
  parameter int unsigned V_BP     = c_v_bp_def
) (
  input  logic       clk,
  input  logic       reset,
  output logic       active,
  output logic       vactive,
  output logic       hsync_on,
  output logic       vsync_on,
  output logic       frame_boundary,
  output logic       frame_first,
  output logic [1:0] lane
);

  localparam int unsigned c_h_total = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned c_v_total = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int          c_hw      = $clog2(c_h_total);
  localparam int          c_vw      = $clog2(c_v_total);

  if (!h_active_ok(H_ACTIVE)) begin : g_h_active_check
    $error("video_timing: H_ACTIVE must be a multiple of 4");
  end

  logic [c_hw-1:0] r_h;
  logic [c_vw-1:0] r_v;
  logic [31:0]     w_h;
  logic [31:0]     w_v;
  logic            w_h_last;
  logic            w_v_last;

  assign w_h      = 32'(r_h);
  assign w_v      = 32'(r_v);
  assign w_h_last = (w_h == c_h_total - 1);
  assign w_v_last = (w_v == c_v_total - 1);

  // Reset parks the raster on the last pixel so the first clock after release
  // is a frame boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h <= c_hw'(c_h_total - 1);
      r_v <= c_vw'(c_v_total - 1);
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + c_vw'(1);
    end else begin
      r_h <= r_h + c_hw'(1);
    end
  end

  assign vactive        = (w_v < V_ACTIVE);
  assign active         = (w_h < H_ACTIVE) && vactive;
  assign hsync_on       = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
  assign vsync_on       = (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC);
  assign frame_boundary = w_h_last && w_v_last;
  assign frame_first    = (w_h == 0) && (w_v == 0);
  // H_ACTIVE is word aligned, so the low counter bits are the byte lane.
  assign lane           = r_h[1:0];

endmodule
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_scanout                                                                 |
// | Display scanout: fetches packed 8-bit indices from the framebuffer, looks  |
// | them up in the palette and drives registered RGB/DE/sync, 3-cycle latency. |
// | Ports: clk, reset (async, active-low), enable, fb_base  -> frame config    |
// |        fb_rd_en/fb_rd_addr/fb_rd_data                   -> framebuffer rd  |
// |        pal_rd_addr/pal_rd_data                          -> palette rd      |
// |        rgb, de, hsync, vsync                            -> video PHY       |
// |        frame_start, vblank                              -> status          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module fb_scanout
  import display_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = c_h_active_def,
  parameter int unsigned H_FP      = c_h_fp_def,
  parameter int unsigned H_SYNC    = c_h_sync_def,
  parameter int unsigned H_BP      = c_h_bp_def,
  parameter int unsigned V_ACTIVE  = c_v_active_def,
  parameter int unsigned V_FP      = c_v_fp_def,
  parameter int unsigned V_SYNC    = c_v_sync_def,
  parameter int unsigned V_BP      = c_v_bp_def,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned FB_ADDR_W = c_fb_addr_w_def
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [FB_ADDR_W-1:0] fb_base,
  output logic                 fb_rd_en,
  output logic [FB_ADDR_W-1:0] fb_rd_addr,
  input  logic [31:0]          fb_rd_data,
  output logic [7:0]           pal_rd_addr,
  input  logic [31:0]          pal_rd_data,
  output logic [23:0]          rgb,
  output logic                 de,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start,
  output logic                 vblank
);

  logic                 w_active;
  logic                 w_vactive;
  logic                 w_hs_on;
  logic                 w_vs_on;
  logic                 w_boundary;
  logic                 w_first;
  logic [1:0]           w_lane;
  logic [FB_ADDR_W-1:0] r_addr;
  logic                 r_en_q;
  logic                 w_fetch;
  pix_ctl_t             w_s0;
  pix_ctl_t             r_s1;
  pix_ctl_t             r_s2;
  logic [31:0]          r_hold;
  logic [31:0]          w_word;
  logic                 w_unused;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk            (clk),
    .reset          (reset),
    .active         (w_active),
    .vactive        (w_vactive),
    .hsync_on       (w_hs_on),
    .vsync_on       (w_vs_on),
    .frame_boundary (w_boundary),
    .frame_first    (w_first),
    .lane           (w_lane)
  );

  // S0: one word read per four visible pixels while the frame is enabled.
  assign w_fetch    = w_active && r_en_q && (w_lane == 2'd0);
  assign fb_rd_en   = w_fetch;
  assign fb_rd_addr = r_addr;

  // Base and enable are only taken at the frame boundary, so a page flip or
  // disable issued mid-frame cannot tear the frame being scanned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_en_q <= 1'b0;
    end else if (w_boundary) begin
      r_addr <= fb_base;
      r_en_q <= enable;
    end else if (w_fetch) begin
      r_addr <= r_addr + FB_ADDR_W'(1);
    end
  end

  always_comb begin
    w_s0        = '0;
    w_s0.active = w_active;
    w_s0.show   = w_active && r_en_q;
    w_s0.k      = w_lane;
    w_s0.hs     = w_hs_on;
    w_s0.vs     = w_vs_on;
    w_s0.fs     = w_first;
    w_s0.vact   = w_vactive;
  end

  // S1/S2 control delay; the lane-0 word is held for the next three pixels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_hold <= '0;
    end else begin
      r_s1 <= w_s0;
      r_s2 <= r_s1;
      if (r_s1.show && (r_s1.k == 2'd0)) begin
        r_hold <= fb_rd_data;
      end
    end
  end

  // S1: lane 0 uses the word arriving this cycle, later lanes the held copy.
  always_comb begin
    w_word      = (r_s1.k == 2'd0) ? fb_rd_data : r_hold;
    pal_rd_addr = 8'h00;
    if (r_s1.show) begin
      case (r_s1.k)
        2'd0:    pal_rd_addr = w_word[7:0];
        2'd1:    pal_rd_addr = w_word[15:8];
        2'd2:    pal_rd_addr = w_word[23:16];
        default: pal_rd_addr = w_word[31:24];
      endcase
    end
  end

  // S3: registered outputs; sync polarity applied here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb         <= 24'h000000;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
      vblank      <= 1'b1;
    end else begin
      rgb         <= r_s2.show ? pal_rd_data[23:0] : 24'h000000;
      de          <= r_s2.active;
      hsync       <= r_s2.hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= r_s2.vs ? SYNC_POL : ~SYNC_POL;
      frame_start <= r_s2.fs;
      vblank      <= ~r_s2.vact;
    end
  end

  // Palette alpha byte and the stage-2 lane are carried but not needed.
  assign w_unused = ^{pal_rd_data[31:24], r_s2.k};

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fb_scanout                                                              |
// | Directed bench for fb_scanout in an 8x4 raster (14x7 totals): reset,       |
// | unpack/lookup, timing pattern, page flip, disable and address wrap.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_fb_scanout;

  logic        clk    = 1'b0;
  logic        clk_en = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] fb_base;
  logic        fb_rd_en;
  logic [15:0] fb_rd_addr;
  logic [31:0] fb_rd_data;
  logic [7:0]  pal_rd_addr;
  logic [31:0] pal_rd_data;
  logic [23:0] rgb;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic        vblank;

  fb_scanout #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (1'b0), .FB_ADDR_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fb_base     (fb_base),
    .fb_rd_en    (fb_rd_en),
    .fb_rd_addr  (fb_rd_addr),
    .fb_rd_data  (fb_rd_data),
    .pal_rd_addr (pal_rd_addr),
    .pal_rd_data (pal_rd_data),
    .rgb         (rgb),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start),
    .vblank      (vblank)
  );

  // Clock can be parked low to observe the asynchronous reset.
  always #5 clk = clk_en ? ~clk : 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: one-cycle read latency; palette[n] = {0,n,n,n}.
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (fb_rd_en) fb_rd_data <= mem[fb_rd_addr];
    pal_rd_data <= {8'h00, pal_rd_addr, pal_rd_addr, pal_rd_addr};
  end

  int          checks = 0;
  int          errors = 0;
  int          rel = 0;
  int          rd_total = 0;
  int          fs_count = 0;
  int          last_fs = 0;
  bit          have_fs = 0;
  bit          mon_on = 0;
  logic [15:0] exp_rd [$];
  logic [23:0] exp_px [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and compare any DUT output events
  // against the scoreboard queues.
  task automatic tick();
    logic [15:0] ea;
    logic [23:0] ep;
    @(negedge clk);
    if (mon_on) begin
      if (fb_rd_en) begin
        rd_total++;
        checks++;
        assert (exp_rd.size() > 0) else begin
          errors++;
          $error("FAIL rd_extra: got read at %0h expected no read", fb_rd_addr);
        end
        if (exp_rd.size() > 0) begin
          ea = exp_rd.pop_front();
          chk("rd_addr", 32'(fb_rd_addr), 32'(ea));
        end
      end
      if (de) begin
        checks++;
        assert (exp_px.size() > 0) else begin
          errors++;
          $error("FAIL px_extra: got rgb %0h expected no pixel", rgb);
        end
        if (exp_px.size() > 0) begin
          ep = exp_px.pop_front();
          chk("rgb", 32'(rgb), 32'(ep));
        end
      end
      if (frame_start) begin
        chk("fs_with_de", 32'(de), 32'd1);
        if (have_fs) chk("fs_period", 32'(cyc - last_fs), 32'd98);
        last_fs  = cyc;
        have_fs  = 1;
        fs_count++;
      end
    end
  endtask

  task automatic wait_until(input int e);
    while (cyc - rel < e) tick();
  endtask

  function automatic logic [31:0] pack_word(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic push_frame(input logic [15:0] base, input logic [7:0] pix0, input bit on);
    for (int i = 0; i < 8; i++) if (on) exp_rd.push_back(base + 16'(i));
    for (int p = 0; p < 32; p++) exp_px.push_back(on ? {3{pix0 + 8'(p)}} : 24'h0);
  endtask

  initial begin
    int n;
    int ln;
    int px;
    reset   = 1'b0;
    enable  = 1'b1;
    fb_base = 16'h0010;
    for (int i = 0; i < 8; i++) begin
      mem[16'h0010 + 16'(i)] = pack_word(8'(4 * i));
      mem[16'h0100 + 16'(i)] = pack_word(8'(8'h40 + 4 * i));
      mem[16'(32'hFFFE + i)] = pack_word(8'(8'hC0 + 4 * i));
    end
    clk_en = 1'b1;

    // Run part of a line, then reset with the clock parked.
    repeat (3) tick();
    reset = 1'b1;
    repeat (8) tick();
    clk_en = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_vblank", 32'(vblank), 32'd1);
    chk("rst_fb_rd_en", 32'(fb_rd_en), 32'd0);
    chk("rst_fb_rd_addr", 32'(fb_rd_addr), 32'h0);
    chk("rst_pal_rd_addr", 32'(pal_rd_addr), 32'h0);
    clk_en = 1'b1;
    repeat (3) tick();

    // Frame 1 from 0x10: pixel p has index p.
    push_frame(16'h0010, 8'h00, 1'b1);
    mon_on = 1;
    rel    = cyc;
    reset  = 1'b1;
    n = 0;
    while (!fb_rd_en && n < 10) begin tick(); n++; end
    chk("first_rd_clock", 32'(cyc - rel + 1), 32'd2);
    n = 0;
    while (!de && n < 20) begin tick(); n++; end
    chk("first_de_clock", 32'(cyc - rel), 32'd4);

    // Page flip mid-frame 1; frame 2 from 0x100.
    wait_until(30);
    fb_base = 16'h0100;
    push_frame(16'h0100, 8'h40, 1'b1);

    // Disable mid-frame 2; frame 3 blank.
    wait_until(150);
    enable = 1'b0;
    push_frame(16'h0000, 8'h00, 1'b0);

    // Mid-frame 3: re-enable with a base near the top of the address space.
    wait_until(199);
    fb_base = 16'hFFFE;
    enable  = 1'b1;
    push_frame(16'hFFFE, 8'hC0, 1'b1);

    // Frame 3 reaches the output after clock 200: check the raster pattern.
    wait_until(200);
    for (int i = 0; i < 98; i++) begin
      ln = i / 14;
      px = i % 14;
      chk($sformatf("pat_de[%0d]", i), 32'(de), 32'((px < 8) && (ln < 4)));
      chk($sformatf("pat_hsync[%0d]", i), 32'(hsync), 32'(!((px >= 10) && (px <= 11))));
      chk($sformatf("pat_vsync[%0d]", i), 32'(vsync), 32'(ln != 5));
      chk($sformatf("pat_vblank[%0d]", i), 32'(vblank), 32'(ln >= 4));
      chk($sformatf("pat_fs[%0d]", i), 32'(frame_start), 32'(i == 0));
      chk($sformatf("pat_rgb[%0d]", i), 32'(rgb), 32'h0);
      tick();
    end

    // Keep frame 5 idle so the scoreboard closes cleanly.
    wait_until(320);
    enable = 1'b0;
    wait_until(380);
    mon_on = 0;
    chk("rd_total", 32'(rd_total), 32'd24);
    chk("rd_queue_left", 32'(exp_rd.size()), 32'd0);
    chk("px_queue_left", 32'(exp_px.size()), 32'd0);
    chk("fs_count", 32'(fs_count), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
